// File: rtl/refresh_arbiter.sv
// Shares the DDR4 command bundle between the scheduler and a tREFI-driven refresh engine.
// Latency: zero-cycle passthrough when idle; PALL one cycle after hold_ack, REF TRP_CYC+1 cycles later.
// Backpressure: hold_req/hold_ack handshake; scheduler slots presented while busy are dropped and flagged.
module refresh_arbiter #(
    parameter int BG_WIDTH     = 2,
    parameter int BANK_WIDTH   = 2,
    parameter int COL_WIDTH    = 10,
    parameter int ROW_WIDTH    = 17,
    parameter int TREFI_CYC    = 2340,
    parameter int TRP_CYC      = 4,
    parameter int TRFC_CYC     = 105,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ref_en,
    input  logic [3:0]              s_write,
    input  logic [3:0]              s_read,
    input  logic [3:0]              s_pre,
    input  logic [3:0]              s_act,
    input  logic [3:0]              s_ref,
    input  logic [3:0]              s_zq,
    input  logic [3:0]              s_nop,
    input  logic [3:0]              s_ap,
    input  logic [3:0]              s_pall,
    input  logic [3:0]              s_half_bl,
    input  logic [4*BG_WIDTH-1:0]   s_bg,
    input  logic [4*BANK_WIDTH-1:0] s_bank,
    input  logic [4*COL_WIDTH-1:0]  s_col,
    input  logic [4*ROW_WIDTH-1:0]  s_row,
    output logic                    hold_req,
    input  logic                    hold_ack,
    output logic [3:0]              ddr_write,
    output logic [3:0]              ddr_read,
    output logic [3:0]              ddr_pre,
    output logic [3:0]              ddr_act,
    output logic [3:0]              ddr_ref,
    output logic [3:0]              ddr_zq,
    output logic [3:0]              ddr_nop,
    output logic [3:0]              ddr_ap,
    output logic [3:0]              ddr_pall,
    output logic [3:0]              ddr_half_bl,
    output logic [4*BG_WIDTH-1:0]   ddr_bg,
    output logic [4*BANK_WIDTH-1:0] ddr_bank,
    output logic [4*COL_WIDTH-1:0]  ddr_col,
    output logic [4*ROW_WIDTH-1:0]  ddr_row,
    output logic [3:0]              ref_pending,
    output logic                    ref_busy,
    output logic                    err_overflow,
    output logic                    err_drop
);

    localparam int REFI_W   = $clog2(TREFI_CYC + 1);
    localparam int WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, HOLD, PALL, WAIT_RP, REF, WAIT_RFC} state_t;

    typedef struct packed {
        logic [3:0]              wr;
        logic [3:0]              rd;
        logic [3:0]              pre;
        logic [3:0]              act;
        logic [3:0]              rf;
        logic [3:0]              zq;
        logic [3:0]              nop;
        logic [3:0]              ap;
        logic [3:0]              pall;
        logic [3:0]              half_bl;
        logic [4*BG_WIDTH-1:0]   bg;
        logic [4*BANK_WIDTH-1:0] bank;
        logic [4*COL_WIDTH-1:0]  col;
        logic [4*ROW_WIDTH-1:0]  row;
    } cmd_bundle_t;

    state_t              state, state_nxt;
    cmd_bundle_t         s_cmd, arb_cmd, ddr_cmd;
    logic [REFI_W-1:0]   refi_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                tick, at_max, ref_issue, wait_done, busy_state, s_active;

    assign tick       = ref_en && (refi_cnt == REFI_W'(TREFI_CYC - 1));
    assign at_max     = (ref_pending == 4'(MAX_POSTPONE));
    assign ref_issue  = (state == REF);
    assign wait_done  = (wait_cnt == '0);
    assign busy_state = (state == PALL) || (state == WAIT_RP) || (state == REF) || (state == WAIT_RFC);
    // Reset forces passthrough immediately so the scheduler never sees a stale refresh bundle.
    assign ref_busy   = busy_state && !rst;
    assign s_active   = |(s_write | s_read | s_pre | s_act | s_ref | s_zq | s_pall);

    always_comb begin
        s_cmd.wr      = s_write;
        s_cmd.rd      = s_read;
        s_cmd.pre     = s_pre;
        s_cmd.act     = s_act;
        s_cmd.rf      = s_ref;
        s_cmd.zq      = s_zq;
        s_cmd.nop     = s_nop;
        s_cmd.ap      = s_ap;
        s_cmd.pall    = s_pall;
        s_cmd.half_bl = s_half_bl;
        s_cmd.bg      = s_bg;
        s_cmd.bank    = s_bank;
        s_cmd.col     = s_col;
        s_cmd.row     = s_row;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        arb_cmd     = '0;
        arb_cmd.nop = 4'b1111;
        case (state)
            IDLE:     if (ref_pending != 4'd0) state_nxt = HOLD;
            HOLD:     if (hold_ack) state_nxt = PALL;
            PALL: begin
                arb_cmd.pre  = 4'b0001;
                arb_cmd.pall = 4'b0001;
                arb_cmd.nop  = 4'b1110;
                state_nxt    = WAIT_RP;
            end
            WAIT_RP:  if (wait_done) state_nxt = REF;
            REF: begin
                arb_cmd.rf  = 4'b0001;
                arb_cmd.nop = 4'b1110;
                state_nxt   = WAIT_RFC;
            end
            // Banks stay closed across a burst, so further REFs skip the PALL.
            WAIT_RFC: if (wait_done) state_nxt = (ref_pending != 4'd0) ? REF : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign ddr_cmd = ref_busy ? arb_cmd : s_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            refi_cnt     <= '0;
            ref_pending  <= 4'd0;
            hold_req     <= 1'b0;
            wait_cnt     <= '0;
            err_overflow <= 1'b0;
            err_drop     <= 1'b0;
        end else begin
            hold_req <= (state_nxt != IDLE);
            if (ref_en) refi_cnt <= tick ? '0 : refi_cnt + 1'b1;
            // A tick coinciding with a REF cancels out.
            if (tick && !ref_issue && !at_max) ref_pending <= ref_pending + 4'd1;
            else if (ref_issue && !tick)       ref_pending <= ref_pending - 4'd1;
            if (tick && at_max)        err_overflow <= 1'b1;
            if (ref_busy && s_active)  err_drop     <= 1'b1;
            if (state == PALL)         wait_cnt <= WAIT_W'(TRP_CYC - 1);
            else if (state == REF)     wait_cnt <= WAIT_W'(TRFC_CYC - 1);
            else if (!wait_done)       wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign ddr_write   = ddr_cmd.wr;
    assign ddr_read    = ddr_cmd.rd;
    assign ddr_pre     = ddr_cmd.pre;
    assign ddr_act     = ddr_cmd.act;
    assign ddr_ref     = ddr_cmd.rf;
    assign ddr_zq      = ddr_cmd.zq;
    assign ddr_nop     = ddr_cmd.nop;
    assign ddr_ap      = ddr_cmd.ap;
    assign ddr_pall    = ddr_cmd.pall;
    assign ddr_half_bl = ddr_cmd.half_bl;
    assign ddr_bg      = ddr_cmd.bg;
    assign ddr_bank    = ddr_cmd.bank;
    assign ddr_col     = ddr_cmd.col;
    assign ddr_row     = ddr_cmd.row;

endmodule

// File: tb/tb_refresh_arbiter.sv
// Scenario bench for refresh_arbiter: PALL/REF events are scoreboarded against expected cycle stamps.
module tb_refresh_arbiter;

    localparam int BG_W = 2, BANK_W = 2, COL_W = 10, ROW_W = 17;
    localparam int EV_PALL = 0, EV_REF = 1;

    logic clk = 1'b0;
    logic rst, ref_en, hold_ack, hold_req;
    logic [3:0] s_write, s_read, s_pre, s_act, s_ref, s_zq, s_nop, s_ap, s_pall, s_half_bl;
    logic [4*BG_W-1:0]   s_bg,   ddr_bg;
    logic [4*BANK_W-1:0] s_bank, ddr_bank;
    logic [4*COL_W-1:0]  s_col,  ddr_col;
    logic [4*ROW_W-1:0]  s_row,  ddr_row;
    logic [3:0] ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop, ddr_ap, ddr_pall, ddr_half_bl;
    logic [3:0] ref_pending;
    logic ref_busy, err_overflow, err_drop;

    typedef struct { int kind; int cyc; } ev_t;
    ev_t exp_q[$];
    ev_t obs_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic hold_seen = 1'b0;

    refresh_arbiter #(
        .BG_WIDTH(BG_W), .BANK_WIDTH(BANK_W), .COL_WIDTH(COL_W), .ROW_WIDTH(ROW_W),
        .TREFI_CYC(100), .TRP_CYC(3), .TRFC_CYC(10), .MAX_POSTPONE(4)
    ) dut (
        .clk(clk), .rst(rst), .ref_en(ref_en),
        .s_write(s_write), .s_read(s_read), .s_pre(s_pre), .s_act(s_act), .s_ref(s_ref),
        .s_zq(s_zq), .s_nop(s_nop), .s_ap(s_ap), .s_pall(s_pall), .s_half_bl(s_half_bl),
        .s_bg(s_bg), .s_bank(s_bank), .s_col(s_col), .s_row(s_row),
        .hold_req(hold_req), .hold_ack(hold_ack),
        .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre), .ddr_act(ddr_act),
        .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop), .ddr_ap(ddr_ap),
        .ddr_pall(ddr_pall), .ddr_half_bl(ddr_half_bl),
        .ddr_bg(ddr_bg), .ddr_bank(ddr_bank), .ddr_col(ddr_col), .ddr_row(ddr_row),
        .ref_pending(ref_pending), .ref_busy(ref_busy),
        .err_overflow(err_overflow), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic sched_idle();
        s_write = 4'b0; s_read = 4'b0; s_pre = 4'b0; s_act = 4'b0; s_ref = 4'b0;
        s_zq = 4'b0; s_nop = 4'b1111; s_ap = 4'b0; s_pall = 4'b0; s_half_bl = 4'b0;
        s_bg = '0; s_bank = '0; s_col = '0; s_row = '0;
    endtask

    task automatic do_reset(input logic en, input logic ack);
        rst = 1'b1; ref_en = en; hold_ack = ack;
        sched_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        hold_seen = 1'b0;
    endtask

    // Steps to the negedge of cycle 'target', logging PALL/REF bus events as they appear.
    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (ddr_pall == 4'b0001 && ddr_pre == 4'b0001 && ddr_nop == 4'b1110)
                obs_q.push_back('{EV_PALL, cyc});
            if (ddr_ref == 4'b0001 && ddr_nop == 4'b1110)
                obs_q.push_back('{EV_REF, cyc});
            if (hold_req) hold_seen = 1'b1;
        end
        if (cyc != target) begin
            checks++; failures++;
            $display("FAIL wait_cyc reached=%0d required=%0d", cyc, target);
        end
    endtask

    task automatic test_reset();
        logic [4*ROW_W-1:0] row_val;
        row_val = {4{17'h1abcd}};
        rst = 1'b1; ref_en = 1'b1; hold_ack = 1'b1;
        sched_idle();
        s_read = 4'b1000; s_nop = 4'b0111; s_row = row_val;
        repeat (2) @(negedge clk);
        checks++; if (hold_req !== 1'b0)     begin failures++; $display("FAIL rst_hold_req got=%b exp=0", hold_req); end
        checks++; if (ref_pending !== 4'd0)  begin failures++; $display("FAIL rst_pending got=%0d exp=0", ref_pending); end
        checks++; if (ref_busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", ref_busy); end
        checks++; if (err_overflow !== 1'b0 || err_drop !== 1'b0)
            begin failures++; $display("FAIL rst_err got=%b%b exp=00", err_overflow, err_drop); end
        checks++; if (ddr_read !== 4'b1000 || ddr_nop !== 4'b0111)
            begin failures++; $display("FAIL rst_mirror_cmd got=%b/%b exp=1000/0111", ddr_read, ddr_nop); end
        checks++; if (ddr_row !== row_val)   begin failures++; $display("FAIL rst_mirror_row got=%h exp=%h", ddr_row, row_val); end
    endtask

    task automatic test_ack_tied();
        ev_t e, o;
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{EV_PALL, 102 + 100*i});
            exp_q.push_back('{EV_REF,  106 + 100*i});
        end
        wait_cyc(105);
        checks++; if (ref_pending !== 4'd1) begin failures++; $display("FAIL t1_pending_before got=%0d exp=1", ref_pending); end
        wait_cyc(107);
        checks++; if (ref_pending !== 4'd0) begin failures++; $display("FAIL t1_pending_after got=%0d exp=0", ref_pending); end
        wait_cyc(116);
        checks++; if (hold_req !== 1'b1) begin failures++; $display("FAIL t1_hold_last_rfc got=%b exp=1", hold_req); end
        wait_cyc(117);
        checks++; if (hold_req !== 1'b0 || ref_busy !== 1'b0)
            begin failures++; $display("FAIL t1_release got=%b%b exp=00", hold_req, ref_busy); end
        wait_cyc(330);
        checks++; if (obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL t1_event_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.kind !== e.kind || o.cyc !== e.cyc)
                begin failures++; $display("FAIL t1_event got=%0d@%0d exp=%0d@%0d", o.kind, o.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_postpone();
        ev_t e, o;
        do_reset(1'b1, 1'b0);
        wait_cyc(349);
        checks++; if (ref_pending !== 4'd3) begin failures++; $display("FAIL t2_pending got=%0d exp=3", ref_pending); end
        checks++; if (hold_req !== 1'b1 || ref_busy !== 1'b0)
            begin failures++; $display("FAIL t2_holding got=%b%b exp=10", hold_req, ref_busy); end
        wait_cyc(350);
        hold_ack = 1'b1;
        exp_q.push_back('{EV_PALL, 351});
        for (int i = 0; i < 3; i++) exp_q.push_back('{EV_REF, 355 + 11*i});
        wait_cyc(387);
        checks++; if (hold_req !== 1'b1) begin failures++; $display("FAIL t2_hold_last got=%b exp=1", hold_req); end
        wait_cyc(388);
        checks++; if (hold_req !== 1'b0 || ref_pending !== 4'd0)
            begin failures++; $display("FAIL t2_release got=%b/%0d exp=0/0", hold_req, ref_pending); end
        wait_cyc(395);
        checks++; if (obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL t2_event_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.kind !== e.kind || o.cyc !== e.cyc)
                begin failures++; $display("FAIL t2_event got=%0d@%0d exp=%0d@%0d", o.kind, o.cyc, e.kind, e.cyc); end
        end
    endtask

    task automatic test_overflow();
        ev_t e, o;
        do_reset(1'b1, 1'b0);
        wait_cyc(499);
        checks++; if (ref_pending !== 4'd4 || err_overflow !== 1'b0)
            begin failures++; $display("FAIL t3_saturate got=%0d/%b exp=4/0", ref_pending, err_overflow); end
        wait_cyc(500);
        checks++; if (ref_pending !== 4'd4 || err_overflow !== 1'b1)
            begin failures++; $display("FAIL t3_overflow got=%0d/%b exp=4/1", ref_pending, err_overflow); end
        wait_cyc(600);
        hold_ack = 1'b1;
        exp_q.push_back('{EV_PALL, 601});
        for (int i = 0; i < 4; i++) exp_q.push_back('{EV_REF, 605 + 11*i});
        wait_cyc(649);
        checks++; if (hold_req !== 1'b0 || ref_pending !== 4'd0 || err_overflow !== 1'b1)
            begin failures++; $display("FAIL t3_after got=%b/%0d/%b exp=0/0/1", hold_req, ref_pending, err_overflow); end
        wait_cyc(660);
        checks++; if (obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL t3_event_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.kind !== e.kind || o.cyc !== e.cyc)
                begin failures++; $display("FAIL t3_event got=%0d@%0d exp=%0d@%0d", o.kind, o.cyc, e.kind, e.cyc); end
        end
        do_reset(1'b1, 1'b1);
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL t3_clear got=%b exp=0", err_overflow); end
    endtask

    task automatic test_drop();
        logic [4*ROW_W-1:0] row_val;
        row_val = {4{17'h0f0f3}};
        do_reset(1'b1, 1'b1);
        wait_cyc(110);
        s_read = 4'b0010; s_nop = 4'b1101;
        #1;
        checks++; if (ddr_read !== 4'b0000 || ddr_nop !== 4'b1111 || ref_busy !== 1'b1)
            begin failures++; $display("FAIL t4_busy_mux got=%b/%b/%b exp=0000/1111/1", ddr_read, ddr_nop, ref_busy); end
        checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL t4_drop_early got=%b exp=0", err_drop); end
        wait_cyc(111);
        checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL t4_drop got=%b exp=1", err_drop); end
        sched_idle();
        wait_cyc(120);
        s_read = 4'b0010; s_nop = 4'b1101; s_row = row_val;
        #1;
        checks++; if (ddr_read !== 4'b0010 || ddr_nop !== 4'b1101 || ref_busy !== 1'b0)
            begin failures++; $display("FAIL t4_pass_cmd got=%b/%b/%b exp=0010/1101/0", ddr_read, ddr_nop, ref_busy); end
        checks++; if (ddr_row !== row_val) begin failures++; $display("FAIL t4_pass_row got=%h exp=%h", ddr_row, row_val); end
        wait_cyc(121);
        checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL t4_drop_sticky got=%b exp=1", err_drop); end
        sched_idle();
    endtask

    task automatic test_reset_mid();
        logic [4*COL_W-1:0] col_val;
        col_val = {4{10'h2a5}};
        do_reset(1'b1, 1'b1);
        wait_cyc(104);
        s_write = 4'b0100; s_nop = 4'b1011; s_col = col_val;
        #1;
        checks++; if (ref_busy !== 1'b1 || ddr_write !== 4'b0000 || ddr_nop !== 4'b1111)
            begin failures++; $display("FAIL t5_wait_rp got=%b/%b/%b exp=1/0000/1111", ref_busy, ddr_write, ddr_nop); end
        rst = 1'b1;
        #1;
        checks++; if (ddr_write !== 4'b0100 || ddr_col !== col_val)
            begin failures++; $display("FAIL t5_mirror_in_rst got=%b/%h exp=0100/%h", ddr_write, ddr_col, col_val); end
        @(negedge clk);
        checks++; if (ref_busy !== 1'b0 || hold_req !== 1'b0 || ref_pending !== 4'd0 || err_drop !== 1'b0)
            begin failures++; $display("FAIL t5_after_rst got=%b%b/%0d/%b exp=00/0/0", ref_busy, hold_req, ref_pending, err_drop); end
        checks++; if (ddr_write !== 4'b0100 || ddr_nop !== 4'b1011 || ddr_col !== col_val)
            begin failures++; $display("FAIL t5_passthrough got=%b/%b/%h exp=0100/1011/%h", ddr_write, ddr_nop, ddr_col, col_val); end
        sched_idle();
    endtask

    task automatic test_ref_en();
        ev_t e, o;
        do_reset(1'b0, 1'b1);
        wait_cyc(500);
        checks++; if (hold_seen !== 1'b0 || ref_pending !== 4'd0)
            begin failures++; $display("FAIL t6_gated got=%b/%0d exp=0/0", hold_seen, ref_pending); end
        ref_en = 1'b1;
        exp_q.push_back('{EV_PALL, 602});
        exp_q.push_back('{EV_REF,  606});
        wait_cyc(599);
        checks++; if (ref_pending !== 4'd0) begin failures++; $display("FAIL t6_pre_tick got=%0d exp=0", ref_pending); end
        wait_cyc(620);
        checks++; if (obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL t6_event_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.kind !== e.kind || o.cyc !== e.cyc)
                begin failures++; $display("FAIL t6_event got=%0d@%0d exp=%0d@%0d", o.kind, o.cyc, e.kind, e.cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_ack_tied();
        test_postpone();
        test_overflow();
        test_drop();
        test_reset_mid();
        test_ref_en();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
